// File: rtl/cmul_seq_if.sv
// cmul_seq_if: operand, result and external-multiplier signals for cmul_seq.
// The conj line exists only when CMUL_CONJ_EN is defined.
// master = operand source / result consumer / multiplier side; slave = cmul_seq.
interface cmul_seq_if #(parameter int DW = 4);
  logic                   in_valid;
  logic                   in_ready;
  logic [DW-1:0]          xr;
  logic [DW-1:0]          xi;
  logic [DW-1:0]          yr;
  logic [DW-1:0]          yi;
`ifdef CMUL_CONJ_EN
  logic                   conj;
`endif
  logic [DW-1:0]          mul_a;
  logic [DW-1:0]          mul_b;
  logic [2*DW-1:0]        mul_p;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [2*DW+1:0] re;
  logic signed [2*DW+1:0] im;

  modport master (
    output in_valid, xr, xi, yr, yi, out_ready, mul_p,
    input  in_ready, out_valid, re, im, mul_a, mul_b
`ifdef CMUL_CONJ_EN
    , output conj
`endif
  );

  modport slave (
    input  in_valid, xr, xi, yr, yi, out_ready, mul_p,
    output in_ready, out_valid, re, im, mul_a, mul_b
`ifdef CMUL_CONJ_EN
    , input conj
`endif
  );
endinterface

// File: rtl/cmul_seq.sv
// cmul_seq: sequential complex multiply x*y (or x*conj(y) with CMUL_CONJ_EN)
// using one external DW x DW unsigned multiplier over four cycles.
// Optional feature macro: CMUL_CONJ_EN (adds the conj input).
module cmul_seq #(
  parameter int DW = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  cmul_seq_if.slave   bus
);
  localparam int AW = 2*DW + 2;

  typedef enum logic [2:0] {IDLE, P0, P1, P2, P3, DONE} state_t;

  state_t               state;
  logic [DW-1:0]        xr_q, xi_q, yr_q, yi_q;
  logic signed [AW-1:0] acc_re, acc_im;
  logic signed [AW-1:0] re_q, im_q;
  logic                 in_ready_q, out_valid_q;
  logic [DW-1:0]        mul_a, mul_b;
  logic signed [AW-1:0] p_ext;
  logic                 conj_q;

`ifdef CMUL_CONJ_EN
  logic                 conj_r;
  assign conj_q = conj_r;
`else
  assign conj_q = 1'b0;
`endif

  // Unsigned product widened with two zero bits so it can be added/subtracted signed.
  function automatic logic signed [AW-1:0] zext(input logic [2*DW-1:0] p);
    return $signed({2'b00, p});
  endfunction

  assign p_ext = zext(bus.mul_p);

  // Multiplier operand decode: state and registered operands only, zero outside P0..P3.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      P0:      begin mul_a = xr_q; mul_b = yr_q; end
      P1:      begin mul_a = xi_q; mul_b = yi_q; end
      P2:      begin mul_a = xr_q; mul_b = yi_q; end
      P3:      begin mul_a = xi_q; mul_b = yr_q; end
      default: begin mul_a = '0;   mul_b = '0;   end
    endcase
  end

  // Control FSM with operand capture, partial-product accumulation and result hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      xr_q        <= '0;
      xi_q        <= '0;
      yr_q        <= '0;
      yi_q        <= '0;
`ifdef CMUL_CONJ_EN
      conj_r      <= 1'b0;
`endif
      acc_re      <= '0;
      acc_im      <= '0;
      re_q        <= '0;
      im_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            xr_q       <= bus.xr;
            xi_q       <= bus.xi;
            yr_q       <= bus.yr;
            yi_q       <= bus.yi;
`ifdef CMUL_CONJ_EN
            conj_r     <= bus.conj;
`endif
            acc_re     <= '0;
            acc_im     <= '0;
            in_ready_q <= 1'b0;
            state      <= P0;
          end
        end
        P0: begin
          acc_re <= acc_re + p_ext;
          state  <= P1;
        end
        P1: begin
          acc_re <= conj_q ? acc_re + p_ext : acc_re - p_ext;
          state  <= P2;
        end
        P2: begin
          acc_im <= conj_q ? acc_im - p_ext : acc_im + p_ext;
          state  <= P3;
        end
        P3: begin
          // Final partial product goes straight into the held result as well.
          acc_im      <= acc_im + p_ext;
          re_q        <= acc_re;
          im_q        <= acc_im + p_ext;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.mul_a     = mul_a;
  assign bus.mul_b     = mul_b;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.re        = re_q;
  assign bus.im        = im_q;
endmodule

// File: tb/tb_cmul_seq.sv
// tb_cmul_seq: scoreboard bench for cmul_seq with a behavioural multiplier
// and complex-arithmetic reference model. Builds with or without CMUL_CONJ_EN.
module tb_cmul_seq;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cmul_seq_if #(.DW(DW)) bus ();

  cmul_seq #(.DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External 4x4 multiplier: purely combinational product.
  assign bus.mul_p = bus.mul_a * bus.mul_b;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int re;
    int im;
    int acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   b2b = 1'b0;
  int   last_acc = -1;
  int   last_hs = -1;
  bit   prev_ov = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Complex product from the algebraic definition.
  function automatic void model(input int xr, input int xi, input int yr, input int yi,
                                input bit cj, output int re, output int im);
    if (!cj) begin
      re = xr*yr - xi*yi;
      im = xr*yi + xi*yr;
    end else begin
      re = xr*yr + xi*yi;
      im = xi*yr - xr*yi;
    end
  endfunction

  // Present operands with in_valid=1 and wait for acceptance; in_valid stays high on return.
  task automatic send(input int xr, input int xi, input int yr, input int yi, input bit cj);
    exp_t e;
    int   er, ei, n;
    bit   ok;
    @(negedge clk);
    bus.xr = xr[DW-1:0];
    bus.xi = xi[DW-1:0];
    bus.yr = yr[DW-1:0];
    bus.yi = yi[DW-1:0];
`ifdef CMUL_CONJ_EN
    bus.conj = cj;
`endif
    bus.in_valid = 1'b1;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 200) begin
      if (bus.in_ready) ok = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    if (!ok) begin
      fail_now("accept_timeout");
      return;
    end
    model(xr, xi, yr, yi, cj, er, ei);
    e.re = er;
    e.im = ei;
    e.acc = cyc;
    if (b2b && last_acc >= 0) check("b2b_spacing", cyc - last_acc, 6);
    last_acc = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
    repeat (2) @(negedge clk);
  endtask

  // Monitor: operand lines idle outside P0..P3, result latency, scoreboard compare.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov = 1'b0;
      end else begin
        if (bus.in_ready || bus.out_valid) begin
          check("mul_a_idle", int'(bus.mul_a), 0);
          check("mul_b_idle", int'(bus.mul_b), 0);
        end
        if (bus.out_valid && !prev_ov) begin
          if (exp_q.size() == 0) fail_now("unexpected_out_valid");
          else check("latency", cyc, exp_q[0].acc + 5);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) fail_now("unexpected_result");
          else begin
            mon_e = exp_q.pop_front();
            check("result_re", int'($signed(bus.re)), mon_e.re);
            check("result_im", int'($signed(bus.im)), mon_e.im);
            last_hs = cyc;
          end
        end
        prev_ov = bus.out_valid;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cnt;
    bit  done;
    int  er, ei, a, b, c, d;
    bit  cj;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.xr = '0; bus.xi = '0; bus.yr = '0; bus.yi = '0;
`ifdef CMUL_CONJ_EN
    bus.conj = 1'b0;
`endif

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_re", int'($signed(bus.re)), 0);
    check("rst_im", int'($signed(bus.im)), 0);
    check("rst_mul_a", int'(bus.mul_a), 0);
    check("rst_mul_b", int'(bus.mul_b), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic transaction and busy window.
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(3, 5, 2, 7, 1'b0);
    bus.in_valid = 1'b0;
    cnt = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1'b1;
      else cnt++;
    end
    check("in_ready_low_cycles", cnt, 5);

    // Extremes.
    send(15, 15, 15, 15, 1'b0);
    bus.in_valid = 1'b0;
    send(0, 15, 0, 15, 1'b0);
    bus.in_valid = 1'b0;
    drain();

`ifdef CMUL_CONJ_EN
    send(3, 5, 2, 7, 1'b1);
    bus.in_valid = 1'b0;
    send(3, 5, 2, 7, 1'b0);
    bus.in_valid = 1'b0;
    send(15, 0, 0, 15, 1'b1);
    bus.in_valid = 1'b0;
    drain();
`endif

    // Backpressure: result held, nothing accepted.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(9, 4, 6, 11, 1'b0);
    bus.xr = 4'd1; bus.xi = 4'd2; bus.yr = 4'd3; bus.yi = 4'd4;
    cnt = 0;
    while (!bus.out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    if (!bus.out_valid) fail_now("bp_out_valid_timeout");
    model(9, 4, 6, 11, 1'b0, er, ei);
    repeat (10) begin
      @(negedge clk);
      check("bp_re", int'($signed(bus.re)), er);
      check("bp_im", int'($signed(bus.im)), ei);
      check("bp_in_ready", int'(bus.in_ready), 0);
      check("bp_out_valid", int'(bus.out_valid), 1);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(2, 13, 7, 5, 1'b0);
    bus.in_valid = 1'b0;
    check("accept_after_handshake", last_acc, last_hs + 1);
    drain();

    // Reset in the middle of P2.
    send(12, 9, 14, 3, 1'b0);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_in_ready", int'(bus.in_ready), 1);
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_re", int'($signed(bus.re)), 0);
    check("midrst_im", int'($signed(bus.im)), 0);
    check("midrst_mul_a", int'(bus.mul_a), 0);
    check("midrst_mul_b", int'(bus.mul_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(1, 1, 1, 1, 1'b0);
    bus.in_valid = 1'b0;
    drain();

    // Back-to-back random operands.
    b2b = 1'b1;
    last_acc = -1;
    for (int k = 0; k < 4; k++) begin
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      c = int'($urandom_range(0, 15));
      d = int'($urandom_range(0, 15));
`ifdef CMUL_CONJ_EN
      cj = 1'($urandom_range(0, 1));
`else
      cj = 1'b0;
`endif
      send(a, b, c, d, cj);
    end
    bus.in_valid = 1'b0;
    b2b = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cmul_seq.md
# cmul_seq

Sequential complex-multiply stage that wraps the 4x4 Vedic multiplier. It accepts one complex operand pair per transaction and time-multiplexes a single external 4x4 multiplier over four cycles. It feeds that multiplier its operand pairs and accumulates the returned partial products into real and imaginary results. It sits between the operand source and the result consumer of the complex multiplier datapath, using valid/ready handshakes on both sides.

## Interface
- DW, 4, operand width per component (unsigned); multiplier product width is 2*DW
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  stage can accept operands
- xr, xi  in  DW each  operand x = xr + j·xi, unsigned
- yr, yi  in  DW each  operand y = yr + j·yi, unsigned
- conj  in  1  compute x·conj(y); present only with CMUL_CONJ_EN
- mul_a, mul_b  out  DW each  operands driven to the external multiplier
- mul_p  in  2*DW  product returned combinationally by the external multiplier in the same cycle
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- re, im  out  2*DW+2 each  signed two's-complement result

## Operation
- FSM states: IDLE, P0, P1, P2, P3, DONE. Encoding is free.
- IDLE
  - in_ready=1.
  - On in_valid, register xr/xi/yr/yi (and conj), clear both accumulators, go to P0.
- Product schedule:
  - P0: mul_a=xr, mul_b=yr → acc_re += p
  - P1: mul_a=xi, mul_b=yi → acc_re −= p (or += when conj)
  - P2: mul_a=xr, mul_b=yi → acc_im += p (or −= when conj)
  - P3: mul_a=xi, mul_b=yr → acc_im += p
- Each Pn samples mul_p at the end of its cycle and advances: P0→P1→P2→P3→DONE.
- mul_p is zero-extended to 2*DW+2 bits before add/subtract. Accumulators are 2*DW+2-bit signed and cannot overflow.
- Result ranges at DW=4:
  - Non-conj: re ∈ [−225, 225], im ∈ [0, 450].
  - Conj: re ∈ [0, 450], im ∈ [−225, 225].
- mul_a and mul_b are 0 in IDLE and DONE. They are decoded from the state and the registered operands only, never from the raw inputs.
- DONE
  - out_valid=1; re/im hold the accumulators and stay stable.
  - On out_ready, go to IDLE.
  - If out_ready stays low, DONE holds indefinitely and in_ready stays 0.
- in_ready is 0 in every state except IDLE. No operand is accepted while a result is pending.
- re/im keep their last value after leaving DONE. They are only meaningful while out_valid=1.
- Reset (asserted at any time, including mid-P*): state=IDLE, accumulators and operand registers cleared, any in-flight transaction discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, re=0, im=0, mul_a=0, mul_b=0.
- Acceptance edge is T (in_valid & in_ready).
  - Cycles T+1..T+4 are P0..P3.
  - out_valid rises after edge T+4, i.e. 4 cycles after acceptance.
- Result handshake at edge R (out_valid & out_ready): in_ready=1 from R+1. Next acceptance is no earlier than edge R+1.
- Peak throughput is one result per 6 cycles.
- Everything is registered except the mul_a/mul_b decode.
- Combinational path through the external multiplier: state reg → mul_a/b → multiplier → mul_p → accumulator, in one cycle.

## Configuration
- CMUL_CONJ_EN
  - Defined: conj port exists and is registered at acceptance. conj=1 yields re = xr·yr + xi·yi and im = xi·yr − xr·yi.
  - Undefined: no conj port. Only x·y is computed, and the add/subtract choice is hard-wired.

## Test plan
- Reset, then x=3+5j, y=2+7j, out_ready=1 → out_valid 4 cycles after acceptance with re=−29, im=31; in_ready low for 5 cycles.
- x=15+15j, y=15+15j → re=0, im=450; then x=0+15j, y=0+15j → re=−225, im=0.
- CMUL_CONJ_EN defined: x=3+5j, y=2+7j, conj=1 → re=41, im=−11. conj=0 in the same build → −29/31.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid; drive in_valid=1 throughout → re/im stable, in_ready=0, no second acceptance. Release → next operand accepted the cycle after the result handshake.
- Assert rst_n low during P2 of a transaction → outputs return to reset values immediately. After release the next transaction x=1+1j, y=1+1j yields re=0, im=2.
- Back-to-back: in_valid and out_ready held high, 4 random operand pairs → each result matches the reference model, spaced 6 cycles apart; mul_a/mul_b are 0 in IDLE and DONE.
